// File: rtl/ct_l2c_sram_pkg.sv
// Shared types and constants for the L2C SRAM access controller and its response FIFO.
package ct_l2c_sram_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 88;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int INIT_LAST      = 2047;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctl_state_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A depth-1 FIFO still needs a 1-bit pointer to keep the vectors legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ct_l2c_sram_resp_fifo.sv
// Register-based response FIFO holding SRAM read data until the consumer takes it.
module ct_l2c_sram_resp_fifo
    import ct_l2c_sram_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int CNT_W     = cnt_width(FIFO_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0]      o_cnt,
    output logic                  o_empty
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage array has no reset; the head is masked to zero while empty,
    // so stale entries are never visible and the array stays plain flops without reset fan-out.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (i_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_rdata = o_empty ? '0 : r_mem[r_head];

endmodule

// File: rtl/ct_l2c_sram_acc_ctrl.sv
// Request-side controller for the 2048x88 single-port L2C SRAM: zero-fill sweep,
// registered SRAM pins, 2-stage read pipe and credit-checked response FIFO.
module ct_l2c_sram_acc_ctrl
    import ct_l2c_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int INIT_EN    = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  resp_vld,
    input  logic                  resp_rdy,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int CNT_W  = cnt_width(FIFO_DEPTH);
    localparam int USED_W = CNT_W + 1;

    ctl_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_done;
    logic                  r_rdy_en;
    logic                  r_rd_s1;
    logic                  r_rd_s2;
    logic [ADDR_WIDTH-1:0] r_sram_a;
    logic                  r_sram_cen;
    logic                  r_sram_gwen;
    logic [DATA_WIDTH-1:0] r_sram_wen;
    logic [DATA_WIDTH-1:0] r_sram_d;

    logic [CNT_W-1:0]      w_fifo_cnt;
    logic                  w_fifo_empty;
    logic [USED_W-1:0]     w_used;
    logic                  w_has_credit;
    logic                  w_req_acc;
    logic                  w_resp_pop;

    // Credits cover FIFO entries plus reads still in the SRAM input/output stages.
    assign w_used       = USED_W'(w_fifo_cnt) + USED_W'(r_rd_s1) + USED_W'(r_rd_s2);
    assign w_has_credit = (w_used < USED_W'(FIFO_DEPTH));
    assign req_rdy      = r_rdy_en & (req_wr | w_has_credit);
    assign w_req_acc    = req_vld & req_rdy;
    assign w_resp_pop   = resp_vld & resp_rdy;

    // NOTE: sequential state uses non-blocking assignments only; idle pin values are
    // assigned first and the state-specific branches below override them.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_init_done <= (INIT_EN == 0);
            r_rdy_en    <= 1'b0;
            r_rd_s1     <= 1'b0;
            r_rd_s2     <= 1'b0;
            r_sram_a    <= '0;
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            r_sram_d    <= '0;
        end else begin
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            r_rd_s1     <= 1'b0;
            r_rd_s2     <= r_rd_s1;
            r_rdy_en    <= r_init_done;

            case (r_state)
                ST_INIT: begin
                    r_sram_a    <= r_init_cnt;
                    r_sram_d    <= '0;
                    r_sram_cen  <= 1'b0;
                    r_sram_gwen <= 1'b0;
                    r_sram_wen  <= '0;
                    r_init_cnt  <= r_init_cnt + 1'b1;
                    if (r_init_cnt == ADDR_WIDTH'(INIT_LAST)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    if (w_req_acc) begin
                        r_sram_a   <= req_addr;
                        r_sram_cen <= 1'b0;
                        if (req_wr) begin
                            r_sram_gwen <= 1'b0;
                            r_sram_wen  <= ~req_wmask;
                            r_sram_d    <= req_wdata;
                        end else begin
                            r_rd_s1 <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    ct_l2c_sram_resp_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .i_clk   (forever_cpuclk),
        .i_rst_n (cpurst_b),
        .i_push  (r_rd_s2),
        .i_wdata (sram_q),
        .i_pop   (w_resp_pop),
        .o_rdata (resp_data),
        .o_cnt   (w_fifo_cnt),
        .o_empty (w_fifo_empty)
    );

    assign resp_vld  = ~w_fifo_empty;
    assign init_done = r_init_done;
    assign sram_a    = r_sram_a;
    assign sram_cen  = r_sram_cen;
    assign sram_gwen = r_sram_gwen;
    assign sram_wen  = r_sram_wen;
    assign sram_d    = r_sram_d;

endmodule

// File: tb/tb_ct_l2c_sram_acc_ctrl.sv
// Bench for ct_l2c_sram_acc_ctrl: behavioural SRAM, array/queue reference model, immediate asserts.
module tb_ct_l2c_sram_acc_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 88;
    localparam int DEPTH = 4;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          resp_vld;
    logic          resp_rdy;
    logic [DW-1:0] resp_data;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_l2c_sram_acc_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .INIT_EN    (1)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .resp_vld       (resp_vld),
        .resp_rdy       (resp_rdy),
        .resp_data      (resp_data),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural single-port SRAM with active-low controls and one-cycle read latency.
    logic [DW-1:0] sram_mem [2048];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            rdy_cyc;
    } resp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            dut_acc = 0;
    logic [DW-1:0] mm [2048];
    resp_t         q [$];
    logic          exp_cen;
    logic          exp_gwen;
    logic [DW-1:0] exp_wen;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd88();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Releases reset (called at a negedge) and watches the whole zero-fill sweep.
    task automatic init_check();
        int n_wr = 0;
        int t = 0;
        bit seq_ok = 1'b1;
        bit gap = 1'b0;
        bit rdy_early = 1'b0;
        req_vld  = 1'b0;
        req_wr   = 1'b0;
        cpurst_b = 1'b1;
        while (!init_done && t < 3000) begin
            @(negedge forever_cpuclk);
            t++;
            if (req_rdy) rdy_early = 1'b1;
            if (!sram_cen) begin
                if (sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 || sram_a !== AW'(n_wr))
                    seq_ok = 1'b0;
                n_wr++;
            end else if (n_wr > 0 && !init_done) begin
                gap = 1'b1;
            end
        end
        chk("init_done_rise", init_done, 1);
        chk("init_write_count", n_wr, 2048);
        chk("init_write_seq", seq_ok, 1);
        chk("init_no_gap", gap, 0);
        chk("init_rdy_low", rdy_early, 0);
        @(negedge forever_cpuclk);
        #1;
        chk("rdy_after_init", req_rdy, 1);
        for (int i = 0; i < 2048; i++) mm[i] = '0;
        q.delete();
        exp_a    = AW'(2047);
        exp_d    = '0;
        exp_cen  = 1'b1;
        exp_gwen = 1'b1;
        exp_wen  = '1;
    endtask

    // One clock of RUN traffic, entered and left at a negedge.
    task automatic cycle(input logic vld, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask, input logic rrdy);
        logic          exp_rdy;
        logic          exp_vld;
        resp_t         r;
        logic          n_cen;
        logic          n_gwen;
        logic [DW-1:0] n_wen;
        logic [DW-1:0] n_d;
        logic [AW-1:0] n_a;
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        resp_rdy  = rrdy;
        #1;
        exp_rdy = wr || (q.size() < DEPTH);
        exp_vld = (q.size() > 0) && (q[0].rdy_cyc <= cyc);
        if (vld && req_rdy) dut_acc++;
        chk("req_rdy", req_rdy, exp_rdy);
        chk("resp_vld", resp_vld, exp_vld);
        if (exp_vld) chk("resp_data", resp_data, q[0].data);
        chk("init_done_hold", init_done, 1);
        chk("sram_cen", sram_cen, exp_cen);
        chk("sram_gwen", sram_gwen, exp_gwen);
        chk("sram_wen", sram_wen, exp_wen);
        if (!exp_cen || exp_cen !== sram_cen) begin
            chk("sram_a", sram_a, exp_a);
            if (!exp_gwen) chk("sram_d", sram_d, exp_d);
        end
        n_a = exp_a;
        n_d = exp_d;
        n_cen = 1'b1;
        n_gwen = 1'b1;
        n_wen = '1;
        if (exp_vld && rrdy) void'(q.pop_front());
        if (vld && exp_rdy) begin
            n_a   = addr;
            n_cen = 1'b0;
            if (wr) begin
                n_gwen   = 1'b0;
                n_wen    = ~wmask;
                n_d      = wdata;
                mm[addr] = (mm[addr] & ~wmask) | (wdata & wmask);
            end else begin
                r.data    = mm[addr];
                r.rdy_cyc = cyc + 3;
                q.push_back(r);
            end
        end
        exp_a    = n_a;
        exp_d    = n_d;
        exp_cen  = n_cen;
        exp_gwen = n_gwen;
        exp_wen  = n_wen;
        @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic rrdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, rrdy);
    endtask

    initial begin
        logic [DW-1:0] pat_a5;
        logic [DW-1:0] ones;
        int            acc_before;
        pat_a5    = {11{8'hA5}};
        ones      = '1;
        cpurst_b  = 1'b0;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        resp_rdy  = 1'b1;
        repeat (3) @(negedge forever_cpuclk);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_sram_cen", sram_cen, 1);
        chk("rst_sram_gwen", sram_gwen, 1);
        chk("rst_sram_wen", sram_wen, ones);
        chk("rst_sram_a", sram_a, 0);
        chk("rst_sram_d", sram_d, 0);

        init_check();

        // Full-mask write then read of the same entry; model enforces the 3-cycle latency.
        cycle(1'b1, 1'b1, AW'(5), pat_a5, ones, 1'b1);
        cycle(1'b1, 1'b0, AW'(5), '0, '0, 1'b1);
        idle(5, 1'b1);

        // Partial write of the low byte into a zeroed entry.
        cycle(1'b1, 1'b1, AW'('h20), ones, DW'(8'hFF), 1'b1);
        cycle(1'b1, 1'b0, AW'('h20), '0, '0, 1'b1);
        idle(5, 1'b1);

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
        idle(5, 1'b1);

        // Consumer stalled: only FIFO_DEPTH reads may be accepted.
        acc_before = dut_acc;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, AW'($urandom_range(0, 31)), '0, '0, 1'b0);
        chk("stall_accepts", dut_acc - acc_before, DEPTH);
        idle(10, 1'b1);
        chk("stall_drained", resp_vld, 0);

        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] m;
            m = ($urandom_range(0, 3) == 0) ? ones : rnd88();
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                  rnd88(), m, $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        // Reset with two entries in the FIFO and two reads still in the SRAM pipe.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, AW'(5), '0, '0, 1'b0);
        chk("pre_reset_vld", resp_vld, 1);
        cpurst_b = 1'b0;
        #1;
        chk("midrst_resp_vld", resp_vld, 0);
        chk("midrst_req_rdy", req_rdy, 0);
        chk("midrst_sram_cen", sram_cen, 1);
        chk("midrst_sram_a", sram_a, 0);
        repeat (2) @(negedge forever_cpuclk);
        chk("midrst_fifo_empty", resp_vld, 0);
        init_check();
        cycle(1'b1, 1'b0, AW'(5), '0, '0, 1'b1);
        idle(5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
